load_store_unit: RTL and testbench

- Initiator side of the data-memory interface. Takes one load or store request at a time from the pipeline and drives memread/memwrite/address/writedata toward the data memory. Captures readdata and returns an aligned, extended result.
- Supports byte, half and word accesses. Sub-word stores use read-modify-write, because the memory writes whole words only.
- Sits between the EX/MEM pipeline stage and the data memory. While busy it stalls the pipeline through req_ready.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane.sv | 49 ++++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and request checks for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    MERGE,
    WR,
    RESP
  } state_t;

  // Alignment rule: halves need an even address, words a multiple of four.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_HALF: return addr_lo[0];
      SZ_WORD: return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // A request is rejected for a reserved size or a misaligned address.
  function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_RSVD) || is_misaligned(size, addr_lo);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane steering: load extract/extend and store merge.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_ld_word,
  input  logic [31:0] i_buf_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  output logic [31:0] o_load_data,
  output logic [31:0] o_merge_data
);

  logic [4:0]  w_shift_amt;
  logic [31:0] w_shifted;

  // Sign- or zero-extend a right-justified sub-word value.
  function automatic logic [31:0] extend(input logic [15:0] val, input logic is_half,
                                         input logic sgn);
    if (is_half)
      return sgn ? {{16{val[15]}}, val} : {16'd0, val};
    else
      return sgn ? {{24{val[7]}}, val[7:0]} : {24'd0, val[7:0]};
  endfunction

  // Load path: shift the addressed lane down to bit 0, then extend.
  always_comb begin
    w_shift_amt = (i_size == SZ_HALF) ? {i_offset[1], 4'b0000} : {i_offset, 3'b000};
    w_shifted   = i_ld_word >> w_shift_amt;
    case (i_size)
      SZ_BYTE: o_load_data = extend(w_shifted[15:0], 1'b0, i_signed);
      SZ_HALF: o_load_data = extend(w_shifted[15:0], 1'b1, i_signed);
      // Words are always aligned here, so the shift amount is zero.
      default: o_load_data = w_shifted;
    endcase
  end

  // Store path: overwrite only the addressed lane of the word read back.
  always_comb begin
    o_merge_data = i_buf_word;
    case (i_size)
      SZ_BYTE: o_merge_data[{i_offset, 3'b000} +: 8]     = i_wdata[7:0];
      SZ_HALF: o_merge_data[{i_offset[1], 4'b0000} +: 16] = i_wdata[15:0];
      default: o_merge_data = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, sub-word stores by read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int READ_LAT  = 2,  // 1..15
  parameter int WRITE_CYC = 1   // 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic        mem_memwrite,
  output logic        mem_memread,
  input  logic [31:0] mem_readdata
);

  localparam logic [3:0] RD_LAST = 4'(READ_LAT - 1);
  localparam logic [3:0] WR_LAST = 4'(WRITE_CYC - 1);

  // Control state
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ready;
  logic        r_memread;
  logic        r_memwrite;
  logic [31:0] r_address;
  logic [31:0] r_wbuf;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  // Captured request and read-back data
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdbuf;

  logic        w_accept;
  logic        w_bad;
  logic        w_need_read;
  logic        w_rd_done;
  logic [31:0] w_req_word_addr;
  logic [31:0] w_word_addr;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign w_accept        = req_valid && r_ready;
  assign w_bad           = is_bad_req(req_size, req_addr[1:0]);
  assign w_need_read     = !req_write || (req_size != SZ_WORD);
  assign w_rd_done       = (r_state == RD) && (r_cnt == RD_LAST);
  assign w_req_word_addr = {req_addr[31:2], 2'b00};
  assign w_word_addr     = {r_addr[31:2], 2'b00};

  // The load result is formed straight from the memory word on the sampling
  // cycle so it is ready at the same edge the response is raised.
  lsu_lane u_lane (
    .i_ld_word    (mem_readdata),
    .i_buf_word   (r_rdbuf),
    .i_wdata      (r_wdata),
    .i_offset     (r_addr[1:0]),
    .i_size       (r_size),
    .i_signed     (r_signed),
    .o_load_data  (w_load_data),
    .o_merge_data (w_merge_data)
  );

  // Request fields and the read-back word; no reset needed on pure data.
  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && w_accept) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
    end
    if (w_rd_done)
      r_rdbuf <= mem_readdata;
  end

  // Transaction FSM with registered strobes, address, write data and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_ready      <= 1'b1;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_address    <= 32'd0;
      r_wbuf       <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_cnt   <= 4'd0;
            if (w_bad) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
            end else if (w_need_read) begin
              r_state   <= RD;
              r_memread <= 1'b1;
              r_address <= w_req_word_addr;
            end else begin
              r_state    <= WR;
              r_memwrite <= 1'b1;
              r_address  <= w_req_word_addr;
              r_wbuf     <= req_wdata;
            end
          end
        end
        RD: begin
          if (r_cnt == RD_LAST) begin
            r_memread <= 1'b0;
            r_address <= 32'd0;
            r_cnt     <= 4'd0;
            if (!r_write) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b0;
              r_resp_rdata <= w_load_data;
            end else begin
              r_state <= MERGE;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        MERGE: begin
          r_state    <= WR;
          r_memwrite <= 1'b1;
          r_address  <= w_word_addr;
          r_wbuf     <= w_merge_data;
        end
        WR: begin
          if (r_cnt == WR_LAST) begin
            r_memwrite   <= 1'b0;
            r_wbuf       <= 32'd0;
            r_address    <= 32'd0;
            r_cnt        <= 4'd0;
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = r_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_err      = r_resp_err;
  assign mem_address   = r_address;
  assign mem_writedata = r_wbuf;
  assign mem_memwrite  = r_memwrite;
  assign mem_memread   = r_memread;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a word-array memory and reference model.
module tb_load_store_unit;

  localparam int RL = 2;
  localparam int WC = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [31:0] mem_readdata;

  int checks = 0;
  int errors = 0;
  int proto_bad = 0;
  int addr_bad = 0;

  logic [31:0] bmem [64];
  logic [31:0] ref_mem [64];
  logic        init_mem;

  always #5 clk = ~clk;

  load_store_unit #(.READ_LAT(RL), .WRITE_CYC(WC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_readdata(mem_readdata)
  );

  // Bench data memory: word k holds k after init; whole-word writes only.
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 64; k++) bmem[k] <= 32'(k);
    end else if (mem_memwrite && mem_address < 32'd256) begin
      bmem[mem_address[7:2]] <= mem_writedata;
    end
  end

  assign mem_readdata = (mem_memread && mem_address < 32'd256) ? bmem[mem_address[7:2]] : 32'h0BAD0BAD;

  // Interface rules that must hold on every cycle.
  always @(negedge clk) begin
    if (mem_memread && mem_memwrite) proto_bad++;
    if (!mem_memread && !mem_memwrite && (mem_address != 32'd0 || mem_writedata != 32'd0)) proto_bad++;
  end

  // ---------------- reference model ----------------
  function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic int ref_lat(input logic wr, input logic [1:0] sz, input logic err);
    if (err) return 1;
    if (!wr) return RL + 1;
    if (sz == 2'd2) return WC + 1;
    return RL + WC + 2;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] sz,
                                           input logic sg, input logic [31:0] addr);
    logic [31:0] v;
    int sh;
    sh = 8 * int'(addr % 4);
    if (sz == 2'd0) begin
      v = (word >> sh) & 32'hFF;
      if (sg && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (word >> sh) & 32'hFFFF;
      if (sg && v >= 32'd32768) v = v | 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] sz,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd2) return wdata;
    mask = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
    sh = 8 * int'(addr % 4);
    return (old & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  // ---------------- driver ----------------
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nrd, output int nwr, output int waits);
    logic acc;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wdata;
    waits = 0; acc = 1'b0;
    while (!acc && waits < 50) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (!acc) waits++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL accept_timeout addr=%h waited=%0d cycles, required accept", addr, waits);
    end
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1)); req_size = 2'($urandom_range(0, 3));
    req_signed = 1'($urandom_range(0, 1)); req_addr = $urandom; req_wdata = $urandom;
    lat = 1; nrd = 0; nwr = 0;
    while (!resp_valid && lat < 100) begin
      nrd += int'(mem_memread);
      nwr += int'(mem_memwrite);
      if ((mem_memread || mem_memwrite) && mem_address !== {addr[31:2], 2'b00}) addr_bad++;
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (!resp_valid) begin
      errors++;
      $display("FAIL resp_timeout addr=%h no resp_valid after %0d cycles", addr, lat);
    end
    rdata = resp_rdata;
    err = resp_err;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; init_mem = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    init_mem = 1'b0;
    for (int k = 0; k < 64; k++) ref_mem[k] = 32'(k);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++;
    if ({resp_valid, resp_err, mem_memread, mem_memwrite} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {resp_valid, resp_err, mem_memread, mem_memwrite});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_writedata} !== 96'd0) begin
      errors++; $display("FAIL reset_data rdata=%h addr=%h wdata=%h exp 0", resp_rdata, mem_address, mem_writedata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_word();
    logic [31:0] rd; logic er; int lat, nrd, nwr, w;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (rd !== 32'h4 || er !== 1'b0) begin errors++; $display("FAIL load_word rdata=%h err=%b exp 00000004/0", rd, er); end
    checks++;
    if (lat != RL + 1 || nrd != RL || nwr != 0) begin
      errors++; $display("FAIL load_word_timing lat=%0d rd=%0d wr=%0d exp %0d/%0d/0", lat, nrd, nwr, RL + 1, RL);
    end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_resp got %b exp 0", req_ready); end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h4) begin
      errors++; $display("FAIL after_resp ready=%b valid=%b rdata=%h exp 1/0/00000004", req_ready, resp_valid, resp_rdata);
    end
  endtask

  task automatic test_store_word();
    logic [31:0] rd; logic er; int lat, nrd, nwr, w;
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, rd, er, lat, nrd, nwr, w);
    ref_mem[8] = 32'hDEADBEEF;
    checks++;
    if (lat != WC + 1 || nrd != 0 || nwr != WC || rd !== 32'd0 || er !== 1'b0) begin
      errors++; $display("FAIL store_word lat=%0d rd=%0d wr=%0d rdata=%h err=%b exp %0d/0/%0d/0/0", lat, nrd, nwr, rd, er, WC + 1, WC);
    end
    checks++;
    if (bmem[8] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_word_mem got %h exp deadbeef", bmem[8]); end
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_after_store got %h exp deadbeef", rd); end
  endtask

  task automatic test_subword_store();
    logic [31:0] rd; logic er; int lat, nrd, nwr, w;
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'h11223344, rd, er, lat, nrd, nwr, w);
    ref_mem[16] = 32'h11223344;
    do_req(1'b1, 2'd0, 1'b0, 32'h42, 32'h123456AA, rd, er, lat, nrd, nwr, w);
    ref_mem[16] = 32'h11AA3344;
    checks++;
    if (lat != RL + WC + 2 || nrd != RL || nwr != WC || er !== 1'b0) begin
      errors++; $display("FAIL store_byte_timing lat=%0d rd=%0d wr=%0d err=%b exp %0d/%0d/%0d/0", lat, nrd, nwr, er, RL + WC + 2, RL, WC);
    end
    checks++;
    if (bmem[16] !== 32'h11AA3344) begin errors++; $display("FAIL store_byte_mem got %h exp 11aa3344", bmem[16]); end
    do_req(1'b0, 2'd0, 1'b1, 32'h42, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL load_byte_signed got %h exp ffffffaa", rd); end
    do_req(1'b0, 2'd0, 1'b0, 32'h42, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (rd !== 32'h000000AA) begin errors++; $display("FAIL load_byte_unsigned got %h exp 000000aa", rd); end
  endtask

  task automatic test_half_load();
    logic [31:0] rd; logic er; int lat, nrd, nwr, w;
    do_req(1'b1, 2'd2, 1'b0, 32'h44, 32'h8001FFFF, rd, er, lat, nrd, nwr, w);
    ref_mem[17] = 32'h8001FFFF;
    do_req(1'b0, 2'd1, 1'b1, 32'h46, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL load_half_signed got %h exp ffff8001", rd); end
    do_req(1'b0, 2'd1, 1'b0, 32'h46, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (rd !== 32'h00008001) begin errors++; $display("FAIL load_half_unsigned got %h exp 00008001", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat, nrd, nwr, w;
    logic        t_wr [3] = '{1'b0, 1'b1, 1'b0};
    logic [1:0]  t_sz [3] = '{2'd1, 2'd2, 2'd3};
    logic [31:0] t_ad [3] = '{32'h13, 32'h22, 32'h30};
    for (int i = 0; i < 3; i++) begin
      do_req(t_wr[i], t_sz[i], 1'b1, t_ad[i], 32'h5555AAAA, rd, er, lat, nrd, nwr, w);
      checks++;
      if (er !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || rd !== 32'd0) begin
        errors++; $display("FAIL error_case%0d err=%b lat=%0d rd=%0d wr=%0d rdata=%h exp 1/1/0/0/0", i, er, lat, nrd, nwr, rd);
      end
    end
    checks++;
    if (bmem[8] !== ref_mem[8]) begin errors++; $display("FAIL error_mem_untouched got %h exp %h", bmem[8], ref_mem[8]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat, nrd, nwr, w;
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nrd, nwr, w);
    // Request is raised during the response cycle and must wait exactly one edge.
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (w != 1 || rd !== ref_mem[8] || lat != RL + 1) begin
      errors++; $display("FAIL back_to_back waits=%0d rdata=%h lat=%0d exp 1/%h/%0d", w, rd, lat, ref_mem[8], RL + 1);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h4A, 32'hFFFFBEEF, rd, er, lat, nrd, nwr, w);
    ref_mem[18] = ref_store(ref_mem[18], 2'd1, 32'h4A, 32'hFFFFBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h48, 32'h0, rd, er, lat, nrd, nwr, w);
    checks++;
    if (w != 1 || rd !== ref_mem[18]) begin
      errors++; $display("FAIL b2b_half_store waits=%0d rdata=%h exp 1/%h", w, rd, ref_mem[18]);
    end
  endtask

  task automatic test_reset_abort();
    int seen_resp, seen_wr;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h51; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_memread !== 1'b1) begin errors++; $display("FAIL abort_in_rd memread=%b exp 1", mem_memread); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (mem_memread !== 1'b0 || mem_memwrite !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_outputs rd=%b wr=%b valid=%b ready=%b exp 0/0/0/1", mem_memread, mem_memwrite, resp_valid, req_ready);
    end
    rst = 1'b0;
    seen_resp = 0; seen_wr = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      seen_resp += int'(resp_valid);
      seen_wr += int'(mem_memwrite);
    end
    checks++;
    if (seen_resp != 0 || seen_wr != 0) begin
      errors++; $display("FAIL abort_quiet resp=%0d wr=%0d exp 0/0", seen_resp, seen_wr);
    end
    checks++;
    if (bmem[20] !== ref_mem[20]) begin errors++; $display("FAIL abort_mem got %h exp %h", bmem[20], ref_mem[20]); end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wdata, exp_rd; logic er, wr, sg, exp_er; logic [1:0] sz;
    int lat, nrd, nwr, w, exp_nrd, exp_nwr;
    for (int n = 0; n < 300; n++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      addr = 32'($urandom_range(0, 255));
      wdata = $urandom;
      exp_er = ref_err(sz, addr);
      exp_rd = (wr || exp_er) ? 32'd0 : ref_load(ref_mem[addr / 4], sz, sg, addr);
      exp_nrd = (exp_er || (wr && sz == 2'd2)) ? 0 : RL;
      exp_nwr = (exp_er || !wr) ? 0 : WC;
      do_req(wr, sz, sg, addr, wdata, rd, er, lat, nrd, nwr, w);
      if (wr && !exp_er) ref_mem[addr / 4] = ref_store(ref_mem[addr / 4], sz, addr, wdata);
      checks++;
      if (er !== exp_er || rd !== exp_rd) begin
        errors++; $display("FAIL rand%0d_result wr=%b sz=%0d addr=%h err=%b rdata=%h exp %b/%h", n, wr, sz, addr, er, rd, exp_er, exp_rd);
      end
      checks++;
      if (lat != ref_lat(wr, sz, exp_er) || nrd != exp_nrd || nwr != exp_nwr) begin
        errors++; $display("FAIL rand%0d_timing lat=%0d rd=%0d wr=%0d exp %0d/%0d/%0d", n, lat, nrd, nwr, ref_lat(wr, sz, exp_er), exp_nrd, exp_nwr);
      end
      if (n % 8 == 0) begin
        @(posedge clk); #1;
        checks++;
        if (resp_rdata !== exp_rd || resp_valid !== 1'b0) begin
          errors++; $display("FAIL rand%0d_hold rdata=%h valid=%b exp %h/0", n, resp_rdata, resp_valid, exp_rd);
        end
      end
    end
    for (int k = 0; k < 64; k++) begin
      checks++;
      if (bmem[k] !== ref_mem[k]) begin errors++; $display("FAIL mem_word%0d got %h exp %h", k, bmem[k], ref_mem[k]); end
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (proto_bad != 0) begin errors++; $display("FAIL strobe_rules violations=%0d exp 0", proto_bad); end
    checks++;
    if (addr_bad != 0) begin errors++; $display("FAIL strobe_address violations=%0d exp 0", addr_bad); end
  endtask

  initial begin
    rst = 1'b1; init_mem = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    test_reset();
    test_load_word();
    test_store_word();
    test_subword_store();
    test_half_load();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
